// File: rtl/wb_pkg.sv
// Shared types and default sizes for the write-back port scheduler.
package wb_pkg;
  localparam int WB_DW = 16;
  localparam int WB_AW = 3;
  localparam int WB_CW = 16;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_PEND = 1'b1
  } wb_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear and increment enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] max_val;
  assign max_val = {W{1'b1}};

  // Counter register; clear has priority, holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= {W{1'b0}};
    end else if (inc && (count != max_val)) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end
endmodule

// File: rtl/wb_write_scheduler.sv
// Serialises MEM/WB low/high writes onto a single register-file write port.
// Optional macro WB_SAME_DST_MERGE_EN: equal-destination dual writes collapse to the high write.
module wb_write_scheduler
  import wb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW,
  parameter int CW = WB_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reglow_write_i,
  input  logic          reghigh_write_i,
  input  logic [AW-1:0] rdst1_i,
  input  logic [DW-1:0] rdst1_val_i,
  input  logic [DW-1:0] data_i,
  input  logic          mem_to_reg_i,
  input  logic [AW-1:0] rdst2_i,
  input  logic [DW-1:0] rdst2_val_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic          stall_o,
  output logic [CW-1:0] stall_cnt_o
);
  wb_state_t     state;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] lo_val;
  logic          both;
  logic          split;

  assign lo_val = mem_to_reg_i ? data_i : rdst1_val_i;
  assign both   = reglow_write_i & reghigh_write_i;
`ifdef WB_SAME_DST_MERGE_EN
  assign split  = both & (rdst1_i != rdst2_i);
`else
  assign split  = both;
`endif

  // Write-port mux; reset forces every output low in the same cycle.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = {AW{1'b0}};
    rf_wdata_o = {DW{1'b0}};
    stall_o    = 1'b0;
    if (reset) begin
      rf_we_o = 1'b0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (split) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = rdst1_i;
            rf_wdata_o = lo_val;
            stall_o    = 1'b1;
          end else if (reghigh_write_i) begin
            // Covers high-only and, when merging, equal-destination dual requests.
            rf_we_o    = 1'b1;
            rf_waddr_o = rdst2_i;
            rf_wdata_o = rdst2_val_i;
          end else if (reglow_write_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = rdst1_i;
            rf_wdata_o = lo_val;
          end else begin
            rf_we_o = 1'b0;
          end
        end
        WB_PEND: begin
          rf_we_o    = 1'b1;
          rf_waddr_o = hold_addr;
          rf_wdata_o = hold_data;
        end
        default: begin
          rf_we_o = 1'b0;
        end
      endcase
    end
  end

  // FSM and hold registers for the deferred high write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WB_IDLE;
      hold_addr <= {AW{1'b0}};
      hold_data <= {DW{1'b0}};
    end else begin
      case (state)
        WB_IDLE: begin
          if (split) begin
            hold_addr <= rdst2_i;
            hold_data <= rdst2_val_i;
            state     <= WB_PEND;
          end else begin
            state <= WB_IDLE;
          end
        end
        WB_PEND: state <= WB_IDLE;
        default: state <= WB_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_o),
    .count (stall_cnt_o)
  );
endmodule

// File: tb/tb_wb_write_scheduler.sv
// Table-driven self-checking bench for wb_write_scheduler plus a few multi-cycle sequences.
module tb_wb_write_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        reglow_write_i, reghigh_write_i, mem_to_reg_i;
  logic [2:0]  rdst1_i, rdst2_i;
  logic [15:0] rdst1_val_i, data_i, rdst2_val_i;
  logic        rf_we_o, stall_o;
  logic [2:0]  rf_waddr_o;
  logic [15:0] rf_wdata_o, stall_cnt_o;

  logic        sc_clear, sc_inc;
  logic [1:0]  sc_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] rf [8];

  always #5 clk = ~clk;

  wb_write_scheduler dut (
    .clk(clk), .reset(reset),
    .reglow_write_i(reglow_write_i), .reghigh_write_i(reghigh_write_i),
    .rdst1_i(rdst1_i), .rdst1_val_i(rdst1_val_i), .data_i(data_i),
    .mem_to_reg_i(mem_to_reg_i), .rdst2_i(rdst2_i), .rdst2_val_i(rdst2_val_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  sat_counter #(.W(2)) u_sc (.clk(clk), .clear(sc_clear), .inc(sc_inc), .count(sc_count));

  // Register-file model fed by the write port.
  always @(posedge clk) begin
    if (rf_we_o) rf[rf_waddr_o] <= rf_wdata_o;
  end

  typedef struct {
    logic        rl, rh, mtr;
    logic [2:0]  r1, r2;
    logic [15:0] r1v, dat, r2v;
    logic        e_we, e_stall;
    logic [2:0]  e_addr;
    logic [15:0] e_data, e_cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rl, input logic rh, input logic mtr, input logic [2:0] r1,
                       input logic [15:0] r1v, input logic [15:0] dat, input logic [2:0] r2,
                       input logic [15:0] r2v);
    reglow_write_i = rl; reghigh_write_i = rh; mem_to_reg_i = mtr;
    rdst1_i = r1; rdst1_val_i = r1v; data_i = dat; rdst2_i = r2; rdst2_val_i = r2v;
  endtask

  function automatic vec_t mk(input logic rl, input logic rh, input logic mtr, input logic [2:0] r1,
                              input logic [15:0] r1v, input logic [15:0] dat, input logic [2:0] r2,
                              input logic [15:0] r2v, input logic we, input logic [2:0] addr,
                              input logic [15:0] data, input logic stall, input logic [15:0] cnt);
    vec_t v;
    v.rl = rl; v.rh = rh; v.mtr = mtr; v.r1 = r1; v.r1v = r1v; v.dat = dat;
    v.r2 = r2; v.r2v = r2v; v.e_we = we; v.e_addr = addr; v.e_data = data;
    v.e_stall = stall; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    sc_clear = 1'b1; sc_inc = 1'b0;
    reset = 1'b1;

    // Reset held two cycles with random inputs: all outputs low.
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
            16'($urandom), 3'($urandom), 16'($urandom));
      #3;
      check("rst_we", {31'd0, rf_we_o}, 32'd0);
      check("rst_addr", {29'd0, rf_waddr_o}, 32'd0);
      check("rst_data", {16'd0, rf_wdata_o}, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      if (i == 1) check("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
      next_cycle();
    end
    reset = 1'b0;

    //            rl    rh    mtr   r1    r1v       dat       r2    r2v       we    addr  data      st    cnt
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 3'd3, 16'h1234, 16'hBEEF, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hBEEF, 1'b0, 16'd0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 3'd6, 16'h1234, 16'hBEEF, 3'd1, 16'h9999, 1'b1, 3'd6, 16'h1234, 1'b0, 16'd0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 3'd3, 16'h1111, 16'h2222, 3'd7, 16'hCAFE, 1'b1, 3'd7, 16'hCAFE, 1'b0, 16'd0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 3'd1, 16'h00AA, 16'hFFFF, 3'd2, 16'h5555, 1'b1, 3'd1, 16'h00AA, 1'b1, 16'd0);
    // PEND must ignore its inputs and replay the held write.
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h5555, 1'b0, 16'd1);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 3'd1, 16'h0011, 16'h0000, 3'd2, 16'h0022, 1'b1, 3'd1, 16'h0011, 1'b1, 16'd1);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 3'd1, 16'h0011, 16'h0000, 3'd2, 16'h0022, 1'b1, 3'd2, 16'h0022, 1'b0, 16'd2);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 3'd3, 16'h7777, 16'h0033, 3'd4, 16'h0044, 1'b1, 3'd3, 16'h0033, 1'b1, 16'd2);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 3'd3, 16'h7777, 16'h0033, 3'd4, 16'h0044, 1'b1, 3'd4, 16'h0044, 1'b0, 16'd3);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 3'd5, 16'h0055, 16'h0000, 3'd6, 16'h0066, 1'b1, 3'd5, 16'h0055, 1'b1, 16'd3);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 3'd5, 16'h0055, 16'h0000, 3'd6, 16'h0066, 1'b1, 3'd6, 16'h0066, 1'b0, 16'd4);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'd4);
`ifdef WB_SAME_DST_MERGE_EN
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 3'd4, 16'h0001, 16'h0000, 3'd4, 16'h0002, 1'b1, 3'd4, 16'h0002, 1'b0, 16'd4);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'd4);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'd4);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'd4);
`else
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 3'd4, 16'h0001, 16'h0000, 3'd4, 16'h0002, 1'b1, 3'd4, 16'h0001, 1'b1, 16'd4);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 3'd4, 16'h0001, 16'h0000, 3'd4, 16'h0002, 1'b1, 3'd4, 16'h0002, 1'b0, 16'd5);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'd5);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'd5);
`endif

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rl, vecs[i].rh, vecs[i].mtr, vecs[i].r1, vecs[i].r1v, vecs[i].dat,
            vecs[i].r2, vecs[i].r2v);
      #3;
      check($sformatf("v%0d_we", i), {31'd0, rf_we_o}, {31'd0, vecs[i].e_we});
      check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
      check($sformatf("v%0d_cnt", i), {16'd0, stall_cnt_o}, {16'd0, vecs[i].e_cnt});
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_addr", i), {29'd0, rf_waddr_o}, {29'd0, vecs[i].e_addr});
        check($sformatf("v%0d_data", i), {16'd0, rf_wdata_o}, {16'd0, vecs[i].e_data});
      end else begin
        check($sformatf("v%0d_addr", i), {29'd0, rf_waddr_o}, 32'd0);
        check($sformatf("v%0d_data", i), {16'd0, rf_wdata_o}, 32'd0);
      end
      next_cycle();
    end
    check("rf4_final", {16'd0, rf[4]}, 32'h0002);
    check("rf2_final", {16'd0, rf[2]}, 32'h0022);

    // Reset arriving in PEND drops the held write to r5.
    drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0100, 16'h0000, 3'd5, 16'h0555);
    #3;
    check("pend_rst_first_stall", {31'd0, stall_o}, 32'd1);
    check("pend_rst_first_addr", {29'd0, rf_waddr_o}, 32'd0);
    next_cycle();
    reset = 1'b1;
    #3;
    check("pend_rst_we", {31'd0, rf_we_o}, 32'd0);
    check("pend_rst_addr", {29'd0, rf_waddr_o}, 32'd0);
    check("pend_rst_data", {16'd0, rf_wdata_o}, 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000);
    #3;
    check("post_rst_we", {31'd0, rf_we_o}, 32'd0);
    check("post_rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("post_rst_rf5", {16'd0, rf[5]}, 32'h0055);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 3'd2, 16'h0777, 16'h0000, 3'd5, 16'h0555);
    #3;
    check("idle_after_rst_we", {31'd0, rf_we_o}, 32'd1);
    check("idle_after_rst_addr", {29'd0, rf_waddr_o}, 32'd2);
    check("idle_after_rst_data", {16'd0, rf_wdata_o}, 32'h0777);
    check("idle_after_rst_stall", {31'd0, stall_o}, 32'd0);
    next_cycle();

    // Narrow counter saturates at 3 and does not wrap.
    sc_clear = 1'b0;
    sc_inc = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      check($sformatf("sat_inc%0d", i), {30'd0, sc_count}, (i > 3) ? 32'd3 : 32'(i));
    end
    sc_inc = 1'b0;
    next_cycle();
    check("sat_hold", {30'd0, sc_count}, 32'd3);
    sc_clear = 1'b1;
    sc_inc = 1'b1;
    next_cycle();
    check("sat_clear", {30'd0, sc_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
